// File: rtl/rv_pkg.sv
// Shared RV64 datapath constants and types used by the register file, data memory and ALU.
// Pure declarations: no logic, no latency, no flow control.
package rv_pkg;
  localparam int XLEN    = 64;
  localparam int REG_NUM = 32;
  localparam int ADDR_W  = $clog2(REG_NUM);

  localparam logic [XLEN-1:0] ZERO_VAL = '0;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xlen_t;
  typedef xlen_t [REG_NUM-1:0] reg_arr_t;
endpackage

// File: rtl/reg_read_port.sv
// One combinational register read port: index mux, x0 forcing and, with REG_FILE_BYPASS_EN,
// write-first forwarding of the write-back value. Latency 0, no backpressure.
module reg_read_port
  import rv_pkg::*;
(
  input  reg_idx_t rs_i,
  input  reg_arr_t regs_i,
`ifdef REG_FILE_BYPASS_EN
  input  logic     byp_we_i,
  input  reg_idx_t rd_i,
  input  xlen_t    wdata_i,
`endif
  output xlen_t    rdata_o
);

  always_comb begin
    rdata_o = regs_i[rs_i];
`ifdef REG_FILE_BYPASS_EN
    if (byp_we_i && (rd_i == rs_i)) begin
      rdata_o = wdata_i;
    end
`endif
    // x0 overrides everything, including a forwarded value
    if (rs_i == '0) begin
      rdata_o = ZERO_VAL;
    end
  end

endmodule

// File: rtl/register_file.sv
// RV64 32x64 integer register file: two combinational read ports, one synchronous write port,
// one debug read port. Optional write-first forwarding on rs1/rs2 under REG_FILE_BYPASS_EN.
module register_file
  import rv_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     RegWrite,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  input  reg_idx_t rd,
  input  xlen_t    writeData,
  input  reg_idx_t dbgAddr,
  output xlen_t    readData1,
  output xlen_t    readData2,
  output xlen_t    dbgData
);

  reg_arr_t regs_q;
  logic     wr_en;

  assign wr_en = RegWrite && (rd != '0);

  // Reset clears asynchronously and also masks any write on a coinciding edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= ZERO_VAL;
      end
    end else if (wr_en) begin
      regs_q[rd] <= writeData;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic byp_we;

  // Forwarding is suppressed under reset so every port reads zero while it is held
  assign byp_we = wr_en && !reset;

  reg_read_port u_rp1 (
    .rs_i     (rs1),
    .regs_i   (regs_q),
    .byp_we_i (byp_we),
    .rd_i     (rd),
    .wdata_i  (writeData),
    .rdata_o  (readData1)
  );

  reg_read_port u_rp2 (
    .rs_i     (rs2),
    .regs_i   (regs_q),
    .byp_we_i (byp_we),
    .rd_i     (rd),
    .wdata_i  (writeData),
    .rdata_o  (readData2)
  );
`else
  reg_read_port u_rp1 (
    .rs_i    (rs1),
    .regs_i  (regs_q),
    .rdata_o (readData1)
  );

  reg_read_port u_rp2 (
    .rs_i    (rs2),
    .regs_i  (regs_q),
    .rdata_o (readData2)
  );
`endif

  assign dbgData = (dbgAddr == '0) ? ZERO_VAL : regs_q[dbgAddr];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file; expected values are hand-computed constants.
module tb_register_file;
  import rv_pkg::*;

  logic     clk;
  logic     reset;
  logic     RegWrite;
  reg_idx_t rs1, rs2, rd, dbgAddr;
  xlen_t    writeData;
  xlen_t    readData1, readData2, dbgData;

  int tests;
  int fails;

  register_file dut (
    .clk       (clk),
    .reset     (reset),
    .RegWrite  (RegWrite),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .writeData (writeData),
    .dbgAddr   (dbgAddr),
    .readData1 (readData1),
    .readData2 (readData2),
    .dbgData   (dbgData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input xlen_t obs, input xlen_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input reg_idx_t a, input xlen_t d);
    RegWrite  = 1'b1;
    rd        = a;
    writeData = d;
    tick();
    RegWrite  = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    RegWrite = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; dbgAddr = '0;
    writeData = '0;

    // Reset state
    #2;
    rs1 = 5'd5; rs2 = 5'd31; dbgAddr = 5'd17;
    #1;
    check("rst_rd1", readData1, 64'h0);
    check("rst_rd2", readData2, 64'h0);
    check("rst_dbg", dbgData, 64'h0);
    tick();
    reset = 1'b0;

    // Basic write/read
    wr(5'd10, 64'h1234_5678_9ABC_DEF0);
    rs1 = 5'd10; rs2 = 5'd10; dbgAddr = 5'd10;
    #1;
    check("basic_rd1", readData1, 64'h1234_5678_9ABC_DEF0);
    check("basic_rd2", readData2, 64'h1234_5678_9ABC_DEF0);
    check("basic_dbg", dbgData, 64'h1234_5678_9ABC_DEF0);

    // x0 protection, including same-cycle bypass attempt on index 0
    RegWrite = 1'b1; rd = 5'd0; writeData = 64'hFFFF_FFFF_FFFF_FFFF;
    rs1 = 5'd0; dbgAddr = 5'd0;
    #1;
    check("x0_byp_rd1", readData1, 64'h0);
    tick();
    RegWrite = 1'b0;
    #1;
    check("x0_rd1", readData1, 64'h0);
    check("x0_dbg", dbgData, 64'h0);
    check("x0_other_rd2", readData2, 64'h1234_5678_9ABC_DEF0);

    // Same-cycle hazard
    wr(5'd7, 64'd3);
    RegWrite = 1'b1; rd = 5'd7; writeData = 64'd9;
    rs2 = 5'd7; rs1 = 5'd10; dbgAddr = 5'd7;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("haz_pre_rd2", readData2, 64'd9);
`else
    check("haz_pre_rd2", readData2, 64'd3);
`endif
    check("haz_pre_dbg", dbgData, 64'd3);
    check("haz_pre_rd1", readData1, 64'h1234_5678_9ABC_DEF0);
    tick();
    RegWrite = 1'b0;
    #1;
    check("haz_post_rd2", readData2, 64'd9);
    check("haz_post_dbg", dbgData, 64'd9);

    // Enable low
    RegWrite = 1'b0; rd = 5'd12; writeData = 64'h55;
    tick();
    rs1 = 5'd12; dbgAddr = 5'd12;
    #1;
    check("en_low_rd1", readData1, 64'h0);
    check("en_low_dbg", dbgData, 64'h0);

    // Back-to-back writes to one index, last wins; bit-exact storage
    wr(5'd20, 64'h1);
    wr(5'd20, 64'h2);
    wr(5'd31, 64'h8000_0000_0000_0001);
    rs1 = 5'd20; rs2 = 5'd31;
    #1;
    check("b2b_rd1", readData1, 64'h2);
    check("exact_rd2", readData2, 64'h8000_0000_0000_0001);

    // Reset mid-run, pulsed between edges
    wr(5'd5, 64'hDEAD_BEEF);
    rs1 = 5'd5; rs2 = 5'd10;
    #1;
    check("pre_rst_rd1", readData1, 64'hDEAD_BEEF);
    reset = 1'b1;
    #1;
    check("midrst_rd1", readData1, 64'h0);
    check("midrst_rd2", readData2, 64'h0);
    reset = 1'b0;
    #1;
    check("postrst_rd1", readData1, 64'h0);
    check("postrst_rd2", readData2, 64'h0);

    // Reset coinciding with a write edge
    tick();
    reset = 1'b1;
    RegWrite = 1'b1; rd = 5'd3; writeData = 64'hAA; rs1 = 5'd3;
    #1;
    check("rstwr_byp_rd1", readData1, 64'h0);
    tick();
    reset = 1'b0;
    RegWrite = 1'b0;
    #1;
    check("rstwr_rd1", readData1, 64'h0);

    // Writes resume after deassertion
    wr(5'd3, 64'hAA);
    #1;
    check("resume_rd1", readData1, 64'hAA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
